// File: rtl/shift_unit_arbiter.sv
// shift_unit_arbiter: shares one 16-bit shift datapath (SLL/SRL/SRA) between
// port 0 (ALU) and port 1 (load/store byte-lane alignment).
//   - round-robin grant, valid/ready request handshakes
//   - one-entry registered response stage with backpressure (EMPTY/FULL FSM)
//   - optional saturating grant counters, enabled by defining SHIFT_ARB_STATS_EN
//
// Handshake rule: a transfer happens on a rising clk edge where valid and
// ready are both 1. Ready never depends on the same port's valid beyond
// arbitration: req_ready[i] = slot_free & grant[i], and grant only goes to a
// valid port. rsp_valid/rsp_data/rsp_id/rsp_err stay stable until the
// consumer pops with rsp_ready=1.
//
// Request vectors are packed by port: port i uses req_op[2*i +: 2],
// req_data[DATA_W*i +: DATA_W] and req_shamt[SHAMT_W*i +: SHAMT_W].
// dbg_state (0=EMPTY, 1=FULL) and dbg_rr_ptr expose internal state for checkers.
module shift_unit_arbiter #(
    parameter int DATA_W  = 16,
    parameter int SHAMT_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [3:0]             req_op,
    input  logic [2*DATA_W-1:0]    req_data,
    input  logic [2*SHAMT_W-1:0]   req_shamt,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_id,
    output logic                   rsp_err,
`ifdef SHIFT_ARB_STATS_EN
    output logic [CNT_W-1:0]       grant_cnt0,
    output logic [CNT_W-1:0]       grant_cnt1,
`endif
    output logic                   dbg_state,
    output logic                   dbg_rr_ptr
);

    // The shifter covers every shift amount exactly once only when the
    // data width is a power of two matching the shift-amount width.
    if (DATA_W != (1 << SHAMT_W) || CNT_W < 1) begin : g_param_check
        $error("shift_unit_arbiter: DATA_W must equal 2**SHAMT_W and CNT_W must be >= 1");
    end

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_id_q, rsp_id_d;
    logic                rsp_err_q, rsp_err_d;

    logic [1:0]          grant;
    logic                slot_free;
    logic                accept;
    logic                acc_id;
    logic [1:0]          sel_op;
    logic [DATA_W-1:0]   sel_data;
    logic [SHAMT_W-1:0]  sel_shamt;
    logic [DATA_W-1:0]   shift_res;

    // Arbitration: a lone valid request wins; on contention rr_ptr decides.
    // req_ready is forced low while reset is asserted.
    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11) begin
            grant = rr_ptr_q ? 2'b10 : 2'b01;
        end
        slot_free = (state_q == EMPTY) | rsp_ready;
        req_ready = (rst_n & slot_free) ? grant : 2'b00;
        accept    = |req_ready;
        acc_id    = req_ready[1];
    end

    // Operand mux and shift datapath for whichever port is granted.
    always_comb begin
        sel_op    = acc_id ? req_op[3:2] : req_op[1:0];
        sel_data  = acc_id ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
        sel_shamt = acc_id ? req_shamt[2*SHAMT_W-1:SHAMT_W] : req_shamt[SHAMT_W-1:0];
        case (sel_op)
            OP_SLL:  shift_res = sel_data << sel_shamt;
            OP_SRL:  shift_res = sel_data >> sel_shamt;
            OP_SRA:  shift_res = $unsigned($signed(sel_data) >>> sel_shamt);
            default: shift_res = sel_data;
        endcase
    end

    // Next-state for the response slot, round-robin pointer and held result.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        rsp_err_d  = rsp_err_q;
        if (accept) begin
            state_d    = FULL;
            rr_ptr_d   = ~acc_id;
            rsp_data_d = shift_res;
            rsp_id_d   = acc_id;
            rsp_err_d  = (sel_op == 2'b11);
        end else if (state_q == FULL && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    // Response slot and pointer registers; reset discards any held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            rr_ptr_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign rsp_valid  = (state_q == FULL);
    assign rsp_data   = rsp_data_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_err    = rsp_err_q;
    assign dbg_state  = state_q;
    assign dbg_rr_ptr = rr_ptr_q;

`ifdef SHIFT_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // Saturating per-port accept counters; they never wrap.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (accept && !acc_id && cnt0_q != {CNT_W{1'b1}}) begin
            cnt0_d = cnt0_q + 1'b1;
        end
        if (accept && acc_id && cnt1_q != {CNT_W{1'b1}}) begin
            cnt1_d = cnt1_q + 1'b1;
        end
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Bench for shift_unit_arbiter: directed vectors with hand-computed results,
// an expected-response queue filled by the driver and drained by a monitor.
module tb_shift_unit_arbiter;

  localparam int DATA_W  = 16;
  localparam int SHAMT_W = 4;
`ifdef SHIFT_ARB_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic                 clk;
  logic                 rst_n;
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [3:0]           req_op;
  logic [2*DATA_W-1:0]  req_data;
  logic [2*SHAMT_W-1:0] req_shamt;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DATA_W-1:0]    rsp_data;
  logic                 rsp_id;
  logic                 rsp_err;
  logic                 dbg_state;
  logic                 dbg_rr_ptr;
`ifdef SHIFT_ARB_STATS_EN
  logic [CNT_W-1:0]     grant_cnt0;
  logic [CNT_W-1:0]     grant_cnt1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // expected response: {id, err, data}
  logic [DATA_W+1:0] exp_q[$];

  shift_unit_arbiter #(
    .DATA_W (DATA_W),
    .SHAMT_W(SHAMT_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_shamt (req_shamt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
`ifdef SHIFT_ARB_STATS_EN
    .grant_cnt0(grant_cnt0),
    .grant_cnt1(grant_cnt1),
`endif
    .dbg_state (dbg_state),
    .dbg_rr_ptr(dbg_rr_ptr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  // ---------------- driver ----------------
  task automatic issue(input int p, input logic [1:0] op, input logic [15:0] d,
                       input logic [3:0] sh, input logic [15:0] exp_d, input bit track);
    bit got;
    got = 1'b0;
    req_op[p*2 +: 2]                 = op;
    req_data[p*DATA_W +: DATA_W]     = d;
    req_shamt[p*SHAMT_W +: SHAMT_W]  = sh;
    req_valid[p]                     = 1'b1;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (req_ready[p]) begin
        got = 1'b1;
        if (track) exp_q.push_back({p[0], (op == 2'b11), exp_d});
      end
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [DATA_W+1:0] e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {rsp_id, rsp_err, rsp_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("rsp", {14'd0, rsp_id, rsp_err, rsp_data}, {14'd0, e});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_op    = '0;
    req_data  = '0;
    req_shamt = '0;
    rsp_ready = 1'b1;

    // reset state, with both requests asserted
    #3;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_state", dbg_state, 0);
    check("rst_rr_ptr", dbg_rr_ptr, 0);
    check("rst_req_ready", req_ready, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_req_ready", req_ready, 2'b01);
    req_valid = 2'b00;
    @(posedge clk);
    #1;

    // test 1: port0 SRA, single-cycle latency
    issue(0, 2'b10, 16'h8000, 4'd4, 16'hF800, 1'b1);
    check("t1_latency_valid", rsp_valid, 1);
    check("t1_data", rsp_data, 16'hF800);

    // test 2: port1 SLL then SRL
    issue(1, 2'b00, 16'h00FF, 4'd8, 16'hFF00, 1'b1);
    issue(1, 2'b01, 16'hF000, 4'd12, 16'h000F, 1'b1);

    // boundary shift amounts
    issue(0, 2'b00, 16'h1234, 4'd0,  16'h1234, 1'b1);
    issue(0, 2'b10, 16'h8000, 4'd15, 16'hFFFF, 1'b1);
    issue(0, 2'b10, 16'h7FFF, 4'd15, 16'h0000, 1'b1);
    issue(1, 2'b00, 16'h0001, 4'd15, 16'h8000, 1'b1);
    issue(1, 2'b01, 16'hFFFF, 4'd15, 16'h0001, 1'b1);
    issue(1, 2'b10, 16'hF0F0, 4'd4,  16'hFF0F, 1'b1);
    issue(0, 2'b01, 16'hF0F0, 4'd4,  16'h0F0F, 1'b1);
    drain();

    // test 3: sustained dual requests alternate 0,1,0,1,0,1
    do_reset();
    rsp_ready          = 1'b1;
    req_op             = {2'b01, 2'b00};
    req_data           = {16'h8000, 16'h0001};
    req_shamt          = {4'd1, 4'd1};
    req_valid          = 2'b11;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("t3_grant", req_ready, (c % 2) ? 2'b10 : 2'b01);
      if (c % 2) exp_q.push_back({1'b1, 1'b0, 16'h4000});
      else       exp_q.push_back({1'b0, 1'b0, 16'h0002});
    end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    drain();

    // test 4: backpressure holds result and blocks requests
    rsp_ready = 1'b0;
    issue(0, 2'b00, 16'h0003, 4'd2, 16'h000C, 1'b1);
    req_op[3:2]     = 2'b10;
    req_data[31:16] = 16'h4000;
    req_shamt[7:4]  = 4'd1;
    req_valid[1]    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_ready_blocked", req_ready, 2'b00);
      check("t4_valid_held", rsp_valid, 1);
      check("t4_data_stable", rsp_data, 16'h000C);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_pop_accept", req_ready, 2'b10);
    if (req_ready[1]) exp_q.push_back({1'b1, 1'b0, 16'h2000});
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    check("t4_stay_full", dbg_state, 1);
    check("t4_new_data", rsp_data, 16'h2000);
    drain();

    // test 5: reserved op, then async reset while FULL
    rsp_ready = 1'b0;
    issue(0, 2'b11, 16'h1234, 4'd3, 16'h1234, 1'b0);
    check("t5_valid", rsp_valid, 1);
    check("t5_data", rsp_data, 16'h1234);
    check("t5_err", rsp_err, 1);
    check("t5_id", rsp_id, 0);
    check("t5_rr_ptr", dbg_rr_ptr, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", rsp_valid, 0);
    check("t5_async_rr_ptr", dbg_rr_ptr, 0);
    check("t5_async_err", rsp_err, 0);
    check("t5_async_data", rsp_data, 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check("t5_after_state", dbg_state, 0);

`ifdef SHIFT_ARB_STATS_EN
    // test 6: counters saturate at 15 with CNT_W=4
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      issue(0, 2'b00, 16'h0001, 4'd1, 16'h0002, 1'b1);
      if (i == 9) check("t6_cnt0_mid", grant_cnt0, 10);
    end
    drain();
    check("t6_cnt0_sat", grant_cnt0, 15);
    check("t6_cnt1_zero", grant_cnt1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
